// File: rtl/alu_op_sequencer.sv
// Sequences operand/opcode pairs into an external combinational ALU and returns
// each result over a valid/ready channel, either one opcode or a full opcode sweep.
module alu_op_sequencer #(
  parameter int WIDTH   = 8,
  parameter int SEL_W   = 5,
  parameter int MAX_SEL = 18
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [SEL_W-1:0] cmd_sel,
  input  logic             cmd_sweep,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [SEL_W-1:0] alu_sel,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_carry,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_carry,
  output logic [SEL_W-1:0] res_sel,
  output logic             res_err,
  output logic             res_last,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  localparam logic [SEL_W-1:0] MAX_SEL_V = SEL_W'(MAX_SEL);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [SEL_W-1:0] sel_reg;
  logic             sweep_reg;
  logic [WIDTH-1:0] res_data_reg;
  logic             res_carry_reg;
  logic [SEL_W-1:0] res_sel_reg;
  logic             res_err_reg;
  logic             res_last_reg;

  logic accept, resp_done, sweep_more, sel_err;

  assign accept     = (state_reg == IDLE) && cmd_valid;
  assign resp_done  = (state_reg == RESP) && res_ready;
  assign sweep_more = sweep_reg && (sel_reg < MAX_SEL_V);
  // Out-of-range opcodes can only arrive in single mode; the sweep stops at MAX_SEL.
  assign sel_err    = !sweep_reg && (sel_reg > MAX_SEL_V);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (cmd_valid) state_next = ISSUE;
      ISSUE:   state_next = RESP;
      RESP:    if (res_ready) state_next = sweep_more ? ISSUE : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_reg == IDLE);
    busy      = (state_reg != IDLE);
    res_valid = (state_reg == RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg         <= '0;
      b_reg         <= '0;
      sel_reg       <= '0;
      sweep_reg     <= 1'b0;
      res_data_reg  <= '0;
      res_carry_reg <= 1'b0;
      res_sel_reg   <= '0;
      res_err_reg   <= 1'b0;
      res_last_reg  <= 1'b0;
    end else begin
      if (accept) begin
        a_reg     <= cmd_a;
        b_reg     <= cmd_b;
        sel_reg   <= cmd_sweep ? '0 : cmd_sel;
        sweep_reg <= cmd_sweep;
      end
      if (state_reg == ISSUE) begin
        res_data_reg  <= sel_err ? '0 : alu_out;
        res_carry_reg <= sel_err ? 1'b0 : alu_carry;
        res_sel_reg   <= sel_reg;
        res_err_reg   <= sel_err;
        res_last_reg  <= !sweep_reg || (sel_reg == MAX_SEL_V);
      end
      // Advance to the next opcode only on a handshake that continues the sweep.
      if (resp_done && sweep_more) begin
        sel_reg <= sel_reg + SEL_W'(1);
      end
    end
  end

  assign alu_a     = a_reg;
  assign alu_b     = b_reg;
  assign alu_sel   = sel_reg;
  assign res_data  = res_data_reg;
  assign res_carry = res_carry_reg;
  assign res_sel   = res_sel_reg;
  assign res_err   = res_err_reg;
  assign res_last  = res_last_reg;

endmodule
